mul_stream_engine: RTL and testbench

Single-clock, parametrised streaming multiplier engine: successor to the CSR-driven single-shot multiplier path in the AFU. It accepts tagged operand pairs on a valid/ready stream and pushes them through an internal PIPELINE_STAGE-deep multiply pipeline. Results land in a credit-protected output FIFO, so back-pressure never stalls or overflows the pipeline. Signed/unsigned and low/high-half modes are selected per operation; flush and completion counting support host-driven batch jobs.

---
 rtl/mul_stream_pkg.sv | 24 ++
 rtl/mul_stream_engine_if.sv | 31 +++
 rtl/mul_stream_engine_sync_fifo.sv | 48 ++++
 rtl/mul_stream_engine.sv | 122 ++++++++++++
 tb/tb_mul_stream_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_stream_pkg.sv
// Shared types and constants for the streaming multiplier engine.
package mul_stream_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    // Bit positions inside the 2-bit per-operation mode field.
    localparam int MODE_SIGNED = 0;
    localparam int MODE_HIGH   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [1:0]          mode;
        logic [TAG_W-1:0]    tag;
        logic [2*DATA_W-1:0] product;
    } payload_t;

endpackage

// File: rtl/mul_stream_engine_if.sv
// Operand/result stream bundle plus flush and status for mul_stream_engine.
interface mul_stream_engine_if #(
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_a;
    logic [DATA_LEN-1:0] in_b;
    logic [1:0]          in_mode;
    logic [TAG_LEN-1:0]  in_tag;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_result;
    logic [TAG_LEN-1:0]  out_tag;
    logic                out_overflow;
    logic                busy;
    logic [31:0]         done_count;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_overflow, busy, done_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_overflow, busy, done_count
    );

endinterface

// File: rtl/mul_stream_engine_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and clear.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only entries behind a valid count are ever read out.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/mul_stream_engine.sv
// Tagged streaming multiplier: fixed-latency pipeline feeding a credit-protected result FIFO.
// state  | meaning
// IDLE   | nothing in the pipeline or the result FIFO
// ACTIVE | operations in the pipeline or waiting in the result FIFO
// FLUSH  | single cycle after a flush; everything has been discarded
module mul_stream_engine
    import mul_stream_pkg::*;
#(
    parameter int DATA_LEN       = DATA_W,
    parameter int PIPELINE_STAGE = 2,
    parameter int OUT_DEPTH      = 4,
    parameter int TAG_LEN        = TAG_W
) (
    input  logic         clk,
    input  logic         reset,
    mul_stream_engine_if.slave bus
);
    localparam int CNT_W   = $clog2(OUT_DEPTH + PIPELINE_STAGE) + 1;
    localparam int FCNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam int ENTRY_W = DATA_LEN + TAG_LEN + 1;

    state_t                        state_q, state_d;
    payload_t [PIPELINE_STAGE-1:0] pipe_q;
    payload_t                      stage_in;
    payload_t                      stage_out;
    logic [2*DATA_LEN-1:0]         ext_a, ext_b;
    logic [DATA_LEN-1:0]           prod_hi, prod_lo, result;
    logic                          overflow;
    logic [CNT_W-1:0]              inflight;
    logic [FCNT_W-1:0]             fifo_count;
    logic                          fifo_valid;
    logic [ENTRY_W-1:0]            fifo_head;
    logic                          accept, pop;
    logic [31:0]                   done_q;

    // Credit: every accepted op already owns a FIFO slot, so the pipeline never stalls.
    assign bus.in_ready = !bus.flush && (state_q != FLUSH)
                          && ((inflight + CNT_W'(fifo_count)) < CNT_W'(OUT_DEPTH));
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = fifo_valid && bus.out_ready && !bus.flush;

    always_comb begin
        ext_a = bus.in_mode[MODE_SIGNED] ? {{DATA_LEN{bus.in_a[DATA_LEN-1]}}, bus.in_a}
                                         : {{DATA_LEN{1'b0}}, bus.in_a};
        ext_b = bus.in_mode[MODE_SIGNED] ? {{DATA_LEN{bus.in_b[DATA_LEN-1]}}, bus.in_b}
                                         : {{DATA_LEN{1'b0}}, bus.in_b};
        stage_in         = '0;
        stage_in.valid   = accept;
        stage_in.mode    = bus.in_mode;
        stage_in.tag     = bus.in_tag;
        stage_in.product = ext_a * ext_b;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= stage_in;
            for (int i = 1; i < PIPELINE_STAGE; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPELINE_STAGE; i++) inflight = inflight + CNT_W'(pipe_q[i].valid);
    end

    assign stage_out = pipe_q[PIPELINE_STAGE-1];

    always_comb begin
        prod_hi  = stage_out.product[2*DATA_LEN-1:DATA_LEN];
        prod_lo  = stage_out.product[DATA_LEN-1:0];
        result   = stage_out.mode[MODE_HIGH] ? prod_hi : prod_lo;
        overflow = 1'b0;
        if (!stage_out.mode[MODE_HIGH]) begin
            overflow = stage_out.mode[MODE_SIGNED] ? (prod_hi != {DATA_LEN{prod_lo[DATA_LEN-1]}})
                                                   : (|prod_hi);
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .push  (stage_out.valid),
        .pop   (pop),
        .wdata ({overflow, stage_out.tag, result}),
        .rdata (fifo_head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACTIVE;
            ACTIVE:  if ((inflight == '0) && !fifo_valid && !accept) state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (reset)    done_q <= '0;
        else if (pop) done_q <= done_q + 32'd1;
    end

    assign bus.out_valid = fifo_valid;
    assign {bus.out_overflow, bus.out_tag, bus.out_result} = fifo_valid ? fifo_head : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_count = done_q;

endmodule

// File: tb/tb_mul_stream_engine.sv
// Directed self-checking bench for mul_stream_engine with hand-computed expectations.
module tb_mul_stream_engine;
    localparam int DATA_LEN       = 32;
    localparam int TAG_LEN        = 8;
    localparam int PIPELINE_STAGE = 2;
    localparam int OUT_DEPTH      = 4;

    typedef struct {
        logic [31:0] a, b;
        logic [1:0]  mode;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_done = '0;

    always #5 clk = ~clk;

    mul_stream_engine_if #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN)) bus ();

    mul_stream_engine #(
        .DATA_LEN       (DATA_LEN),
        .PIPELINE_STAGE (PIPELINE_STAGE),
        .OUT_DEPTH      (OUT_DEPTH),
        .TAG_LEN        (TAG_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Issues one op into an idle engine, waits for its result and pops it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                         input logic [7:0] tag, output logic [31:0] res, output logic [7:0] rtag,
                         output logic ovf, output int lat, output logic busy_mid);
        bus.in_a = a; bus.in_b = b; bus.in_mode = mode; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        lat = -1; res = '0; rtag = '0; ovf = 1'b0; busy_mid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            bus.in_valid = 1'b0;
            if (i == 1) busy_mid = bus.busy;
            if (bus.out_valid) begin
                lat = i; res = bus.out_result; rtag = bus.out_tag; ovf = bus.out_overflow;
                break;
            end
        end
        if (lat > 0) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            exp_done = exp_done + 32'd1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done_count !== 32'd0) begin errors++; $display("FAIL reset_done_count: got %0d want 0", bus.done_count); end
        checks++;
        if ({bus.out_overflow, bus.out_tag, bus.out_result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ovf=%b tag=%h res=%h want all 0", bus.out_overflow, bus.out_tag, bus.out_result);
        end
    endtask

    task automatic test_unsigned_low();
        logic [31:0] res; logic [7:0] rtag; logic ovf, busy_mid; int lat;
        do_op(32'd7, 32'd6, 2'd0, 8'h11, res, rtag, ovf, lat, busy_mid);
        checks++; if (lat != PIPELINE_STAGE + 1) begin errors++; $display("FAIL ulow_latency: got %0d want %0d", lat, PIPELINE_STAGE + 1); end
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL ulow_result: got %0d want 42", res); end
        checks++; if (rtag !== 8'h11) begin errors++; $display("FAIL ulow_tag: got %h want 11", rtag); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ulow_overflow: got %b want 0", ovf); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL ulow_busy_active: got %b want 1", busy_mid); end
        checks++; if (bus.done_count !== exp_done) begin errors++; $display("FAIL ulow_done_count: got %0d want %0d", bus.done_count, exp_done); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ulow_busy_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_signed_high();
        vec_t v [4];
        logic [31:0] res; logic [7:0] rtag; logic ovf, busy_mid; int lat;
        v[0] = '{32'hFFFFFFFD, 32'd5, 2'd1, 32'hFFFFFFF1, 1'b0};
        v[1] = '{32'hFFFFFFFD, 32'd5, 2'd3, 32'hFFFFFFFF, 1'b0};
        v[2] = '{32'hFFFFFFFD, 32'd5, 2'd2, 32'h00000004, 1'b0};
        v[3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 2'd1, 32'd9, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].mode, 8'(8'h20 + i), res, rtag, ovf, lat, busy_mid);
            checks++;
            if (res !== v[i].res || ovf !== v[i].ovf || rtag !== 8'(8'h20 + i) || lat != PIPELINE_STAGE + 1) begin
                errors++;
                $display("FAIL signed_high[%0d]: got res=%h ovf=%b tag=%h lat=%0d want res=%h ovf=%b tag=%h lat=%0d",
                         i, res, ovf, rtag, lat, v[i].res, v[i].ovf, 8'(8'h20 + i), PIPELINE_STAGE + 1);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v [5];
        logic [31:0] res; logic [7:0] rtag; logic ovf, busy_mid; int lat;
        v[0] = '{32'h00010000, 32'h00010000, 2'd0, 32'h00000000, 1'b1};
        v[1] = '{32'h00010000, 32'h00010000, 2'd2, 32'h00000001, 1'b0};
        v[2] = '{32'hFFFFFFFD, 32'd5,        2'd0, 32'hFFFFFFF1, 1'b1};
        v[3] = '{32'h40000000, 32'd2,        2'd1, 32'h80000000, 1'b1};
        v[4] = '{32'hC0000000, 32'd2,        2'd1, 32'h80000000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].mode, 8'(8'h30 + i), res, rtag, ovf, lat, busy_mid);
            checks++;
            if (res !== v[i].res || ovf !== v[i].ovf || rtag !== 8'(8'h30 + i)) begin
                errors++;
                $display("FAIL overflow[%0d]: got res=%h ovf=%b tag=%h want res=%h ovf=%b tag=%h",
                         i, res, ovf, rtag, v[i].res, v[i].ovf, 8'(8'h30 + i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int next, got;
        logic acc, pop;
        logic [31:0] base;
        base = exp_done;
        next = 0; got = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1; bus.in_a = 32'(next); bus.in_b = 32'd3; bus.in_mode = 2'd0; bus.in_tag = 8'(next);
            acc = bus.in_ready;
            tick();
            if (acc) next++;
        end
        checks++; if (next != OUT_DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", next, OUT_DEPTH); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'd0) begin errors++; $display("FAIL bp_head: got valid=%b tag=%h want valid=1 tag=00", bus.out_valid, bus.out_tag); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            bus.in_valid = (next < 10); bus.in_a = 32'(next); bus.in_tag = 8'(next);
            acc = bus.in_valid && bus.in_ready;
            pop = bus.out_valid;
            if (pop) begin
                checks++;
                if (bus.out_tag !== 8'(got) || bus.out_result !== 32'(got * 3)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got tag=%h res=%0d want tag=%h res=%0d", got, bus.out_tag, bus.out_result, 8'(got), got * 3);
                end
                got++;
            end
            tick();
            if (acc) next++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        exp_done = exp_done + 32'(got);
        checks++; if (got != 10) begin errors++; $display("FAIL bp_received: got %0d want 10", got); end
        checks++; if (bus.done_count !== base + 32'd10) begin errors++; $display("FAIL bp_done_count: got %0d want %0d", bus.done_count, base + 32'd10); end
    endtask

    task automatic test_throughput();
        int next, got, first_pop, last_pop, acc_done;
        logic acc;
        next = 0; got = 0; first_pop = -1; last_pop = -1; acc_done = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.in_valid = (next < 8); bus.in_a = 32'(next); bus.in_b = 32'd5; bus.in_mode = 2'd0; bus.in_tag = 8'(8'h80 + next);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                got++;
            end
            tick();
            if (acc) begin
                next++;
                if (next == 8) acc_done = c;
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        exp_done = exp_done + 32'(got);
        checks++; if (acc_done != 7) begin errors++; $display("FAIL tp_accept_rate: 8th accept in cycle %0d want 7", acc_done); end
        checks++; if (got != 8 || last_pop - first_pop != 7) begin errors++; $display("FAIL tp_drain_rate: got %0d results over span %0d want 8 over 7", got, last_pop - first_pop); end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [7:0] rtag; logic ovf, busy_mid; int lat;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_a = 32'(k + 1); bus.in_b = 32'd1; bus.in_mode = 2'd0; bus.in_tag = 8'(8'h40 + k);
            tick();
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got in_ready=%b out_valid=%b want 1 1", bus.in_ready, bus.out_valid); end
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_state: got busy=%b want 1", bus.busy); end
        checks++; if (bus.done_count !== exp_done) begin errors++; $display("FAIL flush_done_count: got %0d want %0d", bus.done_count, exp_done); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b want 0", bus.busy); end
        repeat (4) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got out_valid=%b want 0", bus.out_valid); end
        do_op(32'd9, 32'd9, 2'd0, 8'h55, res, rtag, ovf, lat, busy_mid);
        checks++;
        if (res !== 32'd81 || rtag !== 8'h55 || lat != PIPELINE_STAGE + 1) begin
            errors++;
            $display("FAIL flush_after_op: got res=%0d tag=%h lat=%0d want 81 55 %0d", res, rtag, lat, PIPELINE_STAGE + 1);
        end
        checks++; if (bus.done_count !== exp_done) begin errors++; $display("FAIL flush_after_count: got %0d want %0d", bus.done_count, exp_done); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [7:0] rtag; logic ovf, busy_mid; int lat;
        checks++; if (bus.done_count !== exp_done) begin errors++; $display("FAIL rst_pre_count: got %0d want %0d", bus.done_count, exp_done); end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_a = 32'd4; bus.in_b = 32'd4; bus.in_mode = 2'd0; bus.in_tag = 8'(8'h60 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        exp_done = '0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags: got out_valid=%b busy=%b in_ready=%b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
        checks++; if (bus.done_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", bus.done_count); end
        checks++; if ({bus.out_overflow, bus.out_tag, bus.out_result} !== '0) begin errors++; $display("FAIL rst_mid_outputs: got ovf=%b tag=%h res=%h want 0", bus.out_overflow, bus.out_tag, bus.out_result); end
        reset = 1'b0;
        repeat (4) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_leak: got out_valid=%b want 0", bus.out_valid); end
        do_op(32'd2, 32'd3, 2'd0, 8'h77, res, rtag, ovf, lat, busy_mid);
        checks++; if (res !== 32'd6 || rtag !== 8'h77 || bus.done_count !== 32'd1) begin errors++; $display("FAIL rst_mid_after: got res=%0d tag=%h count=%0d want 6 77 1", res, rtag, bus.done_count); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_unsigned_low();
        test_signed_high();
        test_overflow();
        test_back_to_back();
        test_throughput();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
